// File: rtl/change_disp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_disp_pkg : shared types and constants for the change dispenser    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package change_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PAY    = 3'd2,
    ST_DONE   = 3'd3,
    ST_SHORT  = 3'd4
  } state_e;

  localparam int unsigned DENOM_10 = 10;
  localparam int unsigned DENOM_5  = 5;
  localparam int unsigned DENOM_1  = 1;

  localparam logic [1:0] REFILL_SEL_10   = 2'd0;
  localparam logic [1:0] REFILL_SEL_5    = 2'd1;
  localparam logic [1:0] REFILL_SEL_1    = 2'd2;
  localparam logic [1:0] REFILL_SEL_NONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/change_dispenser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_dispenser_if : request, coin hopper, refill and inventory signals |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface change_dispenser_if #(
  parameter int AMT_W = 7,
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             coin_valid;
  logic [AMT_W-1:0] coin_value;
  logic             coin_ack;
  logic             done;
  logic [AMT_W-1:0] paid_total;
  logic             short;
  logic [AMT_W-1:0] short_amount;
  logic             refill_valid;
  logic [1:0]       refill_sel;
  logic [CNT_W-1:0] refill_count;
  logic [CNT_W-1:0] inv_c10;
  logic [CNT_W-1:0] inv_c5;
  logic [CNT_W-1:0] inv_c1;

  modport master (
    output req_valid, req_amount, coin_ack, refill_valid, refill_sel, refill_count,
    input  req_ready, coin_valid, coin_value, done, paid_total, short, short_amount,
    input  inv_c10, inv_c5, inv_c1
  );

  modport slave (
    input  req_valid, req_amount, coin_ack, refill_valid, refill_sel, refill_count,
    output req_ready, coin_valid, coin_value, done, paid_total, short, short_amount,
    output inv_c10, inv_c5, inv_c1
  );
endinterface
`default_nettype wire

// File: rtl/change_dispenser_denom_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | denom_select : greedy choice of the largest payable denomination         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module denom_select
  import change_disp_pkg::*;
#(
  parameter int AMT_W = 7
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic             has_10,
  input  logic             has_5,
  input  logic             has_1,
  output logic             found,
  output logic [AMT_W-1:0] denom
);

  always_comb begin
    found = 1'b0;
    denom = '0;
    if (has_10 && remaining >= AMT_W'(DENOM_10)) begin
      found = 1'b1;
      denom = AMT_W'(DENOM_10);
    end else if (has_5 && remaining >= AMT_W'(DENOM_5)) begin
      found = 1'b1;
      denom = AMT_W'(DENOM_5);
    end else if (has_1 && remaining >= AMT_W'(DENOM_1)) begin
      found = 1'b1;
      denom = AMT_W'(DENOM_1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_dispenser : greedy 10/5/1 coin payout engine with hopper stock.   |
// | CHANGE_DISP_INVENTORY_EN enables inventory tracking, refill and SHORT.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module change_dispenser
  import change_disp_pkg::*;
#(
  parameter int AMT_W    = 7,
  parameter int CNT_W    = 8,
  parameter int INIT_C10 = 8,
  parameter int INIT_C5  = 8,
  parameter int INIT_C1  = 8
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  logic [AMT_W-1:0] coin_value_q, coin_value_d;
  logic             has_10, has_5, has_1;
  logic             sel_found;
  logic [AMT_W-1:0] sel_denom;

  denom_select #(.AMT_W(AMT_W)) u_denom_select (
    .remaining (remaining_q),
    .has_10    (has_10),
    .has_5     (has_5),
    .has_1     (has_1),
    .found     (sel_found),
    .denom     (sel_denom)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      paid_q       <= '0;
      coin_value_q <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      paid_q       <= paid_d;
      coin_value_q <= coin_value_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    paid_d       = paid_q;
    coin_value_d = coin_value_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          remaining_d = bus.req_amount;
          paid_d      = '0;
          state_d     = (bus.req_amount == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_found) begin
          coin_value_d = sel_denom;
          state_d      = ST_PAY;
        end else begin
          state_d = ST_SHORT;
        end
      end
      ST_PAY: begin
        if (bus.coin_ack) begin
          remaining_d = remaining_q - coin_value_q;
          paid_d      = paid_q + coin_value_q;
          state_d     = (remaining_d == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_SHORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low combinationally so a reset withdraws the coin at once.
  assign bus.req_ready  = !reset && (state_q == ST_IDLE);
  assign bus.coin_valid = !reset && (state_q == ST_PAY);
  assign bus.coin_value = reset ? '0 : coin_value_q;
  assign bus.done       = !reset && (state_q == ST_DONE);
  assign bus.paid_total = reset ? '0 : paid_q;

`ifdef CHANGE_DISP_INVENTORY_EN
  logic [CNT_W-1:0] c10_q, c10_d, c5_q, c5_d, c1_q, c1_d;
  logic             add_10, add_5, add_1;
  logic             pay_ack;

  // Refill and payout of the same denomination combine, then clamp at full scale.
  function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] cnt,
                                                input logic             add_en,
                                                input logic [CNT_W-1:0] add,
                                                input logic             dec);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (add_en ? {1'b0, add} : '0) - {{CNT_W{1'b0}}, dec};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign pay_ack = (state_q == ST_PAY) && bus.coin_ack;

  always_comb begin
    add_10 = 1'b0;
    add_5  = 1'b0;
    add_1  = 1'b0;
    case (bus.refill_sel)
      REFILL_SEL_10:   add_10 = bus.refill_valid;
      REFILL_SEL_5:    add_5  = bus.refill_valid;
      REFILL_SEL_1:    add_1  = bus.refill_valid;
      REFILL_SEL_NONE: ;
    endcase
    c10_d = inv_next(c10_q, add_10, bus.refill_count, pay_ack && coin_value_q == AMT_W'(DENOM_10));
    c5_d  = inv_next(c5_q,  add_5,  bus.refill_count, pay_ack && coin_value_q == AMT_W'(DENOM_5));
    c1_d  = inv_next(c1_q,  add_1,  bus.refill_count, pay_ack && coin_value_q == AMT_W'(DENOM_1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c10_q <= CNT_W'(INIT_C10);
      c5_q  <= CNT_W'(INIT_C5);
      c1_q  <= CNT_W'(INIT_C1);
    end else begin
      c10_q <= c10_d;
      c5_q  <= c5_d;
      c1_q  <= c1_d;
    end
  end

  assign has_10           = (c10_q != '0);
  assign has_5            = (c5_q  != '0);
  assign has_1            = (c1_q  != '0);
  assign bus.inv_c10      = c10_q;
  assign bus.inv_c5       = c5_q;
  assign bus.inv_c1       = c1_q;
  assign bus.short        = !reset && (state_q == ST_SHORT);
  assign bus.short_amount = bus.short ? remaining_q : '0;
`else
  logic unused_refill;

  assign has_10           = 1'b1;
  assign has_5            = 1'b1;
  assign has_1            = 1'b1;
  assign bus.inv_c10      = '0;
  assign bus.inv_c5       = '0;
  assign bus.inv_c1       = '0;
  assign bus.short        = 1'b0;
  assign bus.short_amount = '0;
  assign unused_refill    = &{1'b0, bus.refill_valid, bus.refill_sel, bus.refill_count,
                              REFILL_SEL_10, REFILL_SEL_5, REFILL_SEL_1, REFILL_SEL_NONE};
`endif

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_change_dispenser : self-checking bench for change_dispenser           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_change_dispenser;

`ifdef CHANGE_DISP_INVENTORY_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   m10 = 4, m5 = 4, m1 = 4;

  change_dispenser_if #(.AMT_W(7), .CNT_W(8)) bus ();

  change_dispenser #(
    .AMT_W(7), .CNT_W(8), .INIT_C10(4), .INIT_C5(4), .INIT_C1(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int amt;
    int e_short;
    int e_paid;
    int e_sa;
    int e10;
    int e5;
    int e1;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_inv(input string name, input int e10, input int e5, input int e1);
    chk({name, "_c10"}, int'(bus.inv_c10), INV_EN ? e10 : 0);
    chk({name, "_c5"},  int'(bus.inv_c5),  INV_EN ? e5  : 0);
    chk({name, "_c1"},  int'(bus.inv_c1),  INV_EN ? e1  : 0);
  endtask

  // Reference greedy payout against the bench's own inventory model.
  task automatic model_push(input int amt);
    int rem;
    rem = amt;
    while (rem > 0) begin
      if (rem >= 10 && (!INV_EN || m10 > 0)) begin
        exp_q.push_back(10); rem -= 10; m10--;
      end else if (rem >= 5 && (!INV_EN || m5 > 0)) begin
        exp_q.push_back(5); rem -= 5; m5--;
      end else if (rem >= 1 && (!INV_EN || m1 > 0)) begin
        exp_q.push_back(1); rem -= 1; m1--;
      end else begin
        break;
      end
    end
  endtask

  task automatic run_req(input int amt, input int hold, input int e_short, input int e_paid,
                         input int e_sa, input int e_first, input int e_donek);
    int k, first, low, done_k, s10, s5, s1;
    bit fin;
    chk("req_ready_idle", int'(bus.req_ready), 1);
    s10 = m10; s5 = m5; s1 = m1;
    model_push(amt);
    bus.req_valid  = 1'b1;
    bus.req_amount = 7'(amt);
    bus.coin_ack   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_amount = '0;
    k = 1; first = 0; low = hold; done_k = 0; fin = 1'b0;
    while (!fin && k < 200) begin
      bus.coin_ack = (low == 0);
      @(negedge clk);
      if (bus.coin_valid) begin
        if (first == 0) first = k;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL coin_extra: got coin %0d expected none", bus.coin_value);
          fin = 1'b1;
        end else if (bus.coin_ack) begin
          chk("coin_value", int'(bus.coin_value), exp_q.pop_front());
        end else begin
          chk("coin_hold", int'(bus.coin_value), exp_q[0]);
          chk_inv("inv_hold", s10, s5, s1);
          low--;
        end
      end
      if (bus.done || bus.short) begin
        done_k = k;
        chk("short_flag", int'(bus.short), e_short);
        chk("paid_total", int'(bus.paid_total), e_paid);
        chk("short_amount", int'(bus.short_amount), e_sa);
        fin = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.coin_ack = 1'b1;
    if (done_k == 0) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no done/short expected completion amt=%0d", amt);
    end
    if (e_first >= 0) chk("first_coin_cycle", first, e_first);
    if (e_donek >= 0) chk("done_cycle", done_k, e_donek);
    chk("coins_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk("done_pulse_end", int'(bus.done), 0);
    chk("req_ready_back", int'(bus.req_ready), 1);
    chk_inv("inv_model", m10, m5, m1);
  endtask

  vec_t vecs[4];
  int   nv, kk;

  initial begin
`ifdef CHANGE_DISP_INVENTORY_EN
    vecs[0] = '{40, 0, 40, 0, 0, 3, 3};
    vecs[1] = '{10, 0, 10, 0, 0, 1, 3};
    vecs[2] = '{1,  0, 1,  0, 0, 1, 2};
    vecs[3] = '{13, 1, 7,  6, 0, 0, 0};
`else
    vecs[0] = '{40, 0, 40, 0, 0, 0, 0};
    vecs[1] = '{10, 0, 10, 0, 0, 0, 0};
    vecs[2] = '{1,  0, 1,  0, 0, 0, 0};
    vecs[3] = '{13, 0, 13, 0, 0, 0, 0};
`endif
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_amount = '0; bus.coin_ack = 1'b1;
    bus.refill_valid = 1'b0; bus.refill_sel = 2'd0; bus.refill_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_coin_valid", int'(bus.coin_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_paid", int'(bus.paid_total), 0);
    chk_inv("rst_inv", 4, 4, 4);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(bus.req_ready), 1);

    run_req(15, 0, 0, 15, 0, 2, 5);
    chk_inv("inv_after15", 3, 3, 4);
    run_req(0, 0, 0, 0, 0, 0, 1);
    run_req(27, 5, 0, 27, 0, -1, -1);
    chk_inv("inv_after27", 1, 2, 2);

    // Reset during the second coin of a 27 payout.
    bus.req_valid = 1'b1; bus.req_amount = 7'd27; bus.coin_ack = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_amount = '0;
    nv = 0; kk = 0;
    while (nv < 2 && kk < 50) begin
      @(negedge clk);
      if (bus.coin_valid) begin
        nv++;
        if (nv == 1) chk("rst_first_coin", int'(bus.coin_value), 10);
      end
      if (nv < 2) begin @(posedge clk); #1; end
      kk++;
    end
    if (nv < 2) begin
      checks++; errors++;
      $display("FAIL rst_seq_timeout: got %0d coins expected 2", nv);
    end
    reset = 1'b1;
    #1;
    chk("midrst_coin_valid", int'(bus.coin_valid), 0);
    chk("midrst_coin_value", int'(bus.coin_value), 0);
    chk("midrst_req_ready", int'(bus.req_ready), 0);
    chk("midrst_paid", int'(bus.paid_total), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_short", int'(bus.short) + int'(bus.short_amount), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_inv("midrst_inv", 4, 4, 4);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_midrst_done", int'(bus.done) + int'(bus.short), 0);
    chk("post_midrst_ready", int'(bus.req_ready), 1);
    m10 = 4; m5 = 4; m1 = 4;
    run_req(6, 0, 0, 6, 0, 2, 5);
    chk_inv("inv_after6", 4, 3, 3);

    for (int i = 0; i < 4; i++) begin
      run_req(vecs[i].amt, 0, vecs[i].e_short, vecs[i].e_paid, vecs[i].e_sa, -1, -1);
      chk_inv($sformatf("vec%0d_inv", i), vecs[i].e10, vecs[i].e5, vecs[i].e1);
    end

    // Refill to 254, ignored select, then refill coinciding with a 1-dollar ack.
    bus.refill_valid = 1'b1; bus.refill_sel = 2'd2; bus.refill_count = 8'd254;
    @(posedge clk); #1;
    bus.refill_sel = 2'd3; bus.refill_count = 8'd7;
    @(posedge clk); #1;
    bus.refill_valid = 1'b0;
    @(negedge clk);
    chk_inv("refill_inv", 0, 0, 254);
    bus.req_valid = 1'b1; bus.req_amount = 7'd1; bus.coin_ack = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_amount = '0;
    @(posedge clk); #1;
    bus.refill_valid = 1'b1; bus.refill_sel = 2'd2; bus.refill_count = 8'd3;
    @(negedge clk);
    chk("sat_coin_valid", int'(bus.coin_valid), 1);
    chk("sat_coin_value", int'(bus.coin_value), 1);
    @(posedge clk); #1;
    bus.refill_valid = 1'b0;
    @(negedge clk);
    chk_inv("sat_inv", 0, 0, 255);
    chk("sat_done", int'(bus.done), 1);
    chk("sat_paid", int'(bus.paid_total), 1);
    bus.refill_valid = 1'b1; bus.refill_sel = 2'd0; bus.refill_count = 8'd2;
    @(posedge clk); #1;
    bus.refill_valid = 1'b0;
    @(negedge clk);
    chk_inv("refill10_inv", 2, 0, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
